// File: rtl/clint_slave.sv
// Core-local interruptor: memory-mapped msip, mtimecmp and mtime with a
// divided rtc tick, answering single-beat requests with a one-cycle ready pulse.
module clint_slave #(
    parameter logic [31:0] clint_base_addr = 32'h2000000,
    parameter int unsigned clk_divider_rtc = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam int CntW = (clk_divider_rtc < 2) ? 1 : $clog2(clk_divider_rtc + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(clk_divider_rtc);

    localparam logic [15:0] OffMsip     = 16'h0000;
    localparam logic [15:0] OffCmpLo    = 16'h4000;
    localparam logic [15:0] OffCmpHi    = 16'h4004;
    localparam logic [15:0] OffMtimeLo  = 16'hBFF8;
    localparam logic [15:0] OffMtimeHi  = 16'hBFFC;

    logic            ready_q,    ready_d;
    logic [31:0]     rdata_q,    rdata_d;
    logic            msip_q,     msip_d;
    logic            mtip_q,     mtip_d;
    logic [63:0]     mtime_q,    mtime_d;
    logic [63:0]     mtimeCmp_q, mtimeCmp_d;
    logic [CntW-1:0] divCnt_q,   divCnt_d;
    logic            rtcPhase_q, rtcPhase_d;

    logic [15:0] offset;
    logic        accept;
    logic        isWrite;
    logic        rtcWrap;
    logic        rtcTick;
    logic [31:0] readVal;
    logic        unusedInputs;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
        end
        return res;
    endfunction

    // Only the low 16 bits of the offset are decoded, so the subtraction can stay 16 bits wide.
    assign offset       = clint_addr[15:0] - clint_base_addr[15:0];
    assign accept       = clint_valid && !ready_q;
    assign isWrite      = (clint_wstrb != 4'b0000);
    assign rtcWrap      = (divCnt_q == MaxCnt);
    assign rtcTick      = rtcWrap && !rtcPhase_q;
    assign unusedInputs = &{1'b0, clint_instr, clint_addr[31:16]};

    always_comb begin
        readVal = 32'h0;
        case (offset)
            OffMsip:    readVal = {31'h0, msip_q};
            OffCmpLo:   readVal = mtimeCmp_q[31:0];
            OffCmpHi:   readVal = mtimeCmp_q[63:32];
            OffMtimeLo: readVal = mtime_q[31:0];
            OffMtimeHi: readVal = mtime_q[63:32];
            default:    readVal = 32'h0;
        endcase
    end

    always_comb begin
        ready_d    = accept;
        rdata_d    = accept ? readVal : 32'h0;
        msip_d     = msip_q;
        mtimeCmp_d = mtimeCmp_q;
        divCnt_d   = rtcWrap ? '0 : divCnt_q + 1'b1;
        rtcPhase_d = rtcWrap ? ~rtcPhase_q : rtcPhase_q;
        mtime_d    = rtcTick ? mtime_q + 64'd1 : mtime_q;
        mtip_d     = (mtime_q >= mtimeCmp_q);

        // A CPU write to either mtime half overrides the rtc increment for that cycle.
        if (accept && isWrite) begin
            case (offset)
                OffMsip:    if (clint_wstrb[0]) msip_d = clint_wdata[0];
                OffCmpLo:   mtimeCmp_d[31:0]  = mergeBytes(mtimeCmp_q[31:0], clint_wdata, clint_wstrb);
                OffCmpHi:   mtimeCmp_d[63:32] = mergeBytes(mtimeCmp_q[63:32], clint_wdata, clint_wstrb);
                OffMtimeLo: mtime_d = {mtime_q[63:32], mergeBytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
                OffMtimeHi: mtime_d = {mergeBytes(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            mtime_q    <= 64'h0;
            mtimeCmp_q <= 64'hFFFFFFFF_FFFFFFFF;
            divCnt_q   <= '0;
            rtcPhase_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtime_q    <= mtime_d;
            mtimeCmp_q <= mtimeCmp_d;
            divCnt_q   <= divCnt_d;
            rtcPhase_q <= rtcPhase_d;
        end
    end

    assign clint_ready = ready_q;
    assign clint_rdata = rdata_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule
